// File: rtl/booth_mul_pkg.sv
// Shared Booth radix-4 definitions: the digit type, its constants and the triplet decoder.
// Latency: none. This package holds only types and a pure function.
// Backpressure: not applicable.
// Contents: booth_digit_t (ZERO, POS1, POS2, NEG1, NEG2) and booth_decode().
package booth_mul_pkg;

   // One recoded Booth digit from the set {-2,-1,0,+1,+2}.
   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_digit_t;

   // Maps the overlapping triplet {q[2i+1], q[2i], q[2i-1]} to its digit.
   function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
      booth_digit_t d;
      case (triplet)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;   // 000 and 111
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_mul_recode.sv
// One Booth digit selector: turns a triplet and M into a sign-extended, unshifted partial product.
// Latency: combinational.
// Backpressure: none.
// Ports: triplet (3-bit Booth window), m (signed multiplicand), pp (2*DATA_WIDTH-bit partial product).
module booth_mul_recode
   import booth_mul_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]              triplet,
   input  logic [DATA_WIDTH-1:0]   m,
   output logic [2*DATA_WIDTH-1:0] pp
);

   localparam int W = DATA_WIDTH;

   // Two extra bits: 2*M and -(-2^(W-1)) need headroom beyond W bits.
   logic [W+1:0] m_ext;
   logic [W+1:0] m_x2;
   logic [W+1:0] sel;
   booth_digit_t digit;

   assign m_ext = {{2{m[W-1]}}, m};
   assign m_x2  = m_ext << 1;
   assign digit = booth_decode(triplet);

   always_comb begin
      sel = '0;
      case (digit)
         POS1:    sel = m_ext;
         POS2:    sel = m_x2;
         NEG1:    sel = -m_ext;
         NEG2:    sel = -m_x2;
         default: sel = '0;
      endcase
   end

   assign pp = {{(W-2){sel[W+1]}}, sel};

endmodule

// File: rtl/booth_mul.sv
// Signed DATA_WIDTH x DATA_WIDTH radix-4 Booth multiplier producing the full product on {HI,LO}.
// Latency: 0 cycles by default; 1 cycle when BOOTH_MUL_OUT_REG_EN is defined (output register).
// Backpressure: none; a new operand pair may be presented every cycle.
// Ports: clk, rst (sync, active-high, register build only), Q (multiplier), M (multiplicand), HI/LO.
// DATA_WIDTH must be even and at least 4.
module booth_mul
   import booth_mul_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] Q,
   input  logic [DATA_WIDTH-1:0] M,
   output logic [DATA_WIDTH-1:0] HI,
   output logic [DATA_WIDTH-1:0] LO
);

   localparam int W = DATA_WIDTH;
   localparam int N = DATA_WIDTH / 2;

   logic [2*W-1:0] product;

   // Each stage recodes one digit and adds its shifted partial product to the
   // running sum of the previous stage; wraparound is the intended modulo-2^(2W) sum.
   for (genvar i = 0; i < N; i++) begin : g_pp
      logic [2:0]     trip;
      logic [2*W-1:0] pp;
      logic [2*W-1:0] acc;

      if (i == 0) begin : g_first
         assign trip = {Q[1], Q[0], 1'b0};
         assign acc  = pp;
      end else begin : g_rest
         assign trip = Q[2*i+1:2*i-1];
         assign acc  = g_pp[i-1].acc + (pp << (2*i));
      end

      booth_mul_recode #(.DATA_WIDTH(W)) u_recode (
         .triplet (trip),
         .m       (M),
         .pp      (pp)
      );
   end

   assign product = g_pp[N-1].acc;

`ifdef BOOTH_MUL_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         HI <= '0;
         LO <= '0;
      end else begin
         HI <= product[2*W-1:W];
         LO <= product[W-1:0];
      end
   end
`else
   // Clock and reset are kept on the port list for drop-in compatibility only.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   assign HI = product[2*W-1:W];
   assign LO = product[W-1:0];
`endif

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul (DATA_WIDTH=32), combinational or registered build.
// Latency: checks one half-cycle after operands are driven (covers both build variants).
// Backpressure: none.
module tb_booth_mul;

   localparam int W = 32;
`ifdef BOOTH_MUL_OUT_REG_EN
   localparam bit REG_MODE = 1'b1;
`else
   localparam bit REG_MODE = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] Q   = '0;
   logic [W-1:0] M   = '0;
   logic [W-1:0] HI;
   logic [W-1:0] LO;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2*W-1:0] exp;
      logic [W-1:0]   q;
      logic [W-1:0]   m;
      bit             r;
   } item_t;

   item_t sb[$];

   always #5 clk = ~clk;

   booth_mul #(.DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .Q   (Q),
      .M   (M),
      .HI  (HI),
      .LO  (LO)
   );

   // Reference: plain signed 64-bit multiply of the two operands.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa;
      longint sb_;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
   endfunction

   // Drive operands on the falling edge and record what must appear.
   task automatic drive(input logic [W-1:0] q, input logic [W-1:0] m, input bit r);
      item_t it;
      @(negedge clk);
      Q   = q;
      M   = m;
      rst = r;
      it.q = q;
      it.m = m;
      it.r = r;
      it.exp = (r && REG_MODE) ? '0 : ref_mul(q, m);
      sb.push_back(it);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         4:       return W'($urandom_range(0, 255));
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: one rising edge after each drive the output reflects that drive.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            it = sb.pop_front();
            n_checks++;
            if ({HI, LO} !== it.exp) begin
               n_fail++;
               $display("FAIL product q=%h m=%h rst=%0d: got HI=%h LO=%h, expected HI=%h LO=%h",
                        it.q, it.m, it.r, HI, LO, it.exp[2*W-1:W], it.exp[W-1:0]);
            end
         end
      end
   end

   initial begin
      int wait_cycles;

      // Reset state (register build: cleared; combinational build: reset ignored).
      drive(32'd123, 32'd456, 1'b1);
      drive(32'd7,   32'd9,   1'b1);

      // Directed cases.
      drive(32'd10, 32'd5, 1'b0);
      drive(32'd10, -32'sd5, 1'b0);
      drive(-32'sd10, -32'sd5, 1'b0);
      drive(32'd12345, 32'd0, 1'b0);
      drive(32'd0, -32'sd77, 1'b0);
      drive(-32'sd1, 32'd0, 1'b0);
      drive(32'd2000, 32'd2000, 1'b0);
      drive(32'h8000_0000, 32'h8000_0000, 1'b0);
      drive(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
      drive(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);

      // Reset priority over capture, then first edge after release loads product.
      drive(32'd10, 32'd5, 1'b0);
      drive(32'd10, 32'd5, 1'b1);
      drive(32'd10, 32'd5, 1'b0);

      // Randomized operand pairs with occasional reset pulses.
      for (int i = 0; i < 1200; i++) begin
         drive(pick_operand(), pick_operand(), ($urandom_range(0, 49) == 0));
      end
      drive(32'd3, -32'sd4, 1'b0);

      wait_cycles = 0;
      while (sb.size() != 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
